// File: rtl/cpu_hazard_if.sv
// Operand hazard bundle between the p2 decode slot and the hazard unit.
// Carries the pipeline freeze, p2 operand info and forward/stall results.
interface cpu_hazard_if;
  logic       stall;
  logic       p2_valid;
  logic [4:0] p2_reg_a;
  logic [4:0] p2_reg_b;
  logic       p2_uses_a;
  logic       p2_uses_b;
  logic       p2_b_is_const;
  logic [4:0] p2_reg_d;
  logic       p2_is_load;
  logic       p2_bypass_a3;
  logic       p2_bypass_b3;
  logic       p2_bypass_a4;
  logic       p2_bypass_b4;
  logic       hazard_stall;
  logic [4:0] p3_reg_d;
  logic [4:0] p4_reg_d;

  modport master (
    output stall, p2_valid, p2_reg_a, p2_reg_b,
    output p2_uses_a, p2_uses_b, p2_b_is_const,
    output p2_reg_d, p2_is_load,
    input  p2_bypass_a3, p2_bypass_b3,
    input  p2_bypass_a4, p2_bypass_b4,
    input  hazard_stall, p3_reg_d, p4_reg_d
  );

  modport slave (
    input  stall, p2_valid, p2_reg_a, p2_reg_b,
    input  p2_uses_a, p2_uses_b, p2_b_is_const,
    input  p2_reg_d, p2_is_load,
    output p2_bypass_a3, p2_bypass_b3,
    output p2_bypass_a4, p2_bypass_b4,
    output hazard_stall, p3_reg_d, p4_reg_d
  );
endinterface

// File: rtl/cpu_hazard.sv
// Forwarding selects and load-use interlock for the p2 operand reads.
// CPU_HAZARD_PERF_EN adds a 32-bit load-use stall counter output.
module cpu_hazard (
  input  logic        clock,
  input  logic        reset,
  cpu_hazard_if.slave hz
`ifdef CPU_HAZARD_PERF_EN
  ,
  output logic [31:0] perf_stall_count
`endif
);

  logic [4:0] p3_reg_d;
  logic       p3_is_load;
  logic [4:0] p4_reg_d;

  logic match_a3;
  logic match_a4;
  logic match_b3;
  logic match_b4;
  logic use_a;
  logic use_b;
  logic load_use;

  assign use_a = hz.p2_valid & hz.p2_uses_a
               & (hz.p2_reg_a != 5'd0);
  assign use_b = hz.p2_valid & hz.p2_uses_b
               & !hz.p2_b_is_const
               & (hz.p2_reg_b != 5'd0);

  assign match_a3 = use_a & (hz.p2_reg_a == p3_reg_d);
  assign match_a4 = use_a & (hz.p2_reg_a == p4_reg_d);
  assign match_b3 = use_b & (hz.p2_reg_b == p3_reg_d);
  assign match_b4 = use_b & (hz.p2_reg_b == p4_reg_d);

  assign load_use = p3_is_load & (match_a3 | match_b3);

  // youngest producer wins; p3 loads cannot forward yet
  assign hz.p2_bypass_a3 = match_a3 & !p3_is_load;
  assign hz.p2_bypass_b3 = match_b3 & !p3_is_load;
  assign hz.p2_bypass_a4 = match_a4 & !match_a3;
  assign hz.p2_bypass_b4 = match_b4 & !match_b3;
  assign hz.hazard_stall = load_use;
  assign hz.p3_reg_d     = p3_reg_d;
  assign hz.p4_reg_d     = p4_reg_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      p3_reg_d   <= 5'd0;
      p3_is_load <= 1'b0;
      p4_reg_d   <= 5'd0;
    end else if (!hz.stall) begin
      p4_reg_d <= p3_reg_d;
      if (load_use || !hz.p2_valid) begin
        p3_reg_d   <= 5'd0;
        p3_is_load <= 1'b0;
      end else begin
        p3_reg_d   <= hz.p2_reg_d;
        p3_is_load <= hz.p2_is_load;
      end
    end
  end

`ifdef CPU_HAZARD_PERF_EN
  always_ff @(posedge clock) begin
    if (reset)
      perf_stall_count <= 32'd0;
    else if (!hz.stall && load_use)
      perf_stall_count <= perf_stall_count + 32'd1;
  end
`endif

endmodule
